// File: rtl/pcs_sync_multilane.sv
// N-lane 1000BASE-X code-group synchronizer: per-lane comma acquisition, error
// hysteresis, SUDI generation and saturating loss-of-sync counters.
module pcs_sync_lane #(
  parameter int ACQ_COMMAS = 3,
  parameter int LOSS_ERRS  = 4,
  parameter int GOOD_RUN   = 4,
  parameter int CNT_W      = 8
) (
  input  logic             Clk,
  input  logic             mr_main_reset,
  input  logic             power_on,
  input  logic             cnt_clear,
  input  logic             i_ind,
  input  logic [9:0]       i_pudi,
  output logic [10:0]      o_sudi,
  output logic             o_sudi_valid,
  output logic             o_status,
  output logic             o_status_nxt,
  output logic [CNT_W-1:0] o_loss_cnt
);
  localparam int CW = $clog2(ACQ_COMMAS + 1);
  localparam int EW = $clog2(LOSS_ERRS + 1);
  localparam int GW = $clog2(GOOD_RUN + 1);

  localparam logic [1:0] LOS = 2'd0;
  localparam logic [1:0] CD  = 2'd1;
  localparam logic [1:0] SA  = 2'd2;

  logic [1:0]       r_state, w_state;
  logic [CW-1:0]    r_ccnt, w_ccnt;
  logic [EW-1:0]    r_err, w_err;
  logic [GW-1:0]    r_good, w_good;
  logic             r_even;
  logic [10:0]      r_sudi;
  logic             r_vld;
  logic [CNT_W-1:0] r_cnt;
  logic             w_comma, w_even, w_bad, w_loss;
  logic [3:0]       w_pop;

  always_comb begin
    w_comma = (i_pudi[9:3] == 7'b0011111) || (i_pudi[9:3] == 7'b1100000);
    w_pop   = 4'($countones(i_pudi));
    // A comma seen while unsynced re-anchors parity to even; otherwise parity alternates.
    w_even  = (power_on && r_state == LOS && w_comma) ? 1'b1 : ~r_even;
    w_bad   = (w_pop < 4'd4) || (w_pop > 4'd6) || (w_comma && !w_even);
    w_state = r_state;
    w_ccnt  = r_ccnt;
    w_err   = r_err;
    w_good  = r_good;
    w_loss  = 1'b0;
    if (!power_on) begin
      w_state = LOS;
    end else if (i_ind) begin
      case (r_state)
        LOS: begin
          if (w_comma) begin
            if (ACQ_COMMAS == 1) begin
              w_state = SA;
              w_err   = '0;
              w_good  = '0;
            end else begin
              w_state = CD;
              w_ccnt  = CW'(1);
            end
          end
        end
        CD: begin
          if (w_bad) begin
            w_state = LOS;
          end else if (w_comma) begin
            w_ccnt = r_ccnt + 1'b1;
            if (int'(w_ccnt) == ACQ_COMMAS) begin
              w_state = SA;
              w_err   = '0;
              w_good  = '0;
            end
          end
        end
        SA: begin
          if (w_bad) begin
            w_err  = r_err + 1'b1;
            w_good = '0;
            if (int'(w_err) == LOSS_ERRS) begin
              w_state = LOS;
              w_loss  = 1'b1;
            end
          end else if (r_err != '0) begin
            if (int'(r_good) + 1 == GOOD_RUN) begin
              w_err  = r_err - 1'b1;
              w_good = '0;
            end else begin
              w_good = r_good + 1'b1;
            end
          end else if (int'(r_good) < GOOD_RUN) begin
            w_good = r_good + 1'b1;
          end
        end
        default: w_state = LOS;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge mr_main_reset) begin
    if (mr_main_reset) begin
      r_state <= LOS;
      r_ccnt  <= '0;
      r_err   <= '0;
      r_good  <= '0;
      r_even  <= 1'b0;
      r_sudi  <= '0;
      r_vld   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state;
      r_ccnt  <= w_ccnt;
      r_err   <= w_err;
      r_good  <= w_good;
      r_vld   <= i_ind;
      if (i_ind) begin
        r_even <= w_even;
        r_sudi <= {w_even, i_pudi};
      end
      if (cnt_clear)
        r_cnt <= w_loss ? CNT_W'(1) : '0;
      else if (w_loss && r_cnt != '1)
        r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_sudi       = r_sudi;
  assign o_sudi_valid = r_vld;
  assign o_status     = (r_state == SA);
  assign o_status_nxt = (w_state == SA);
  assign o_loss_cnt   = r_cnt;
endmodule

module pcs_sync_multilane #(
  parameter int N_LANES    = 4,
  parameter int ACQ_COMMAS = 3,
  parameter int LOSS_ERRS  = 4,
  parameter int GOOD_RUN   = 4,
  parameter int CNT_W      = 8
) (
  input  logic                     Clk,
  input  logic                     mr_main_reset,
  input  logic                     power_on,
  input  logic [10*N_LANES-1:0]    PUDI,
  input  logic [N_LANES-1:0]       PUDI_indicate,
  input  logic                     cnt_clear,
  output logic [11*N_LANES-1:0]    SUDI,
  output logic [N_LANES-1:0]       SUDI_valid,
  output logic [N_LANES-1:0]       code_sync_status,
  output logic                     all_sync,
  output logic [CNT_W*N_LANES-1:0] sync_loss_cnt
);
  logic [N_LANES-1:0] w_stat_nxt;
  logic               r_all_sync;

  for (genvar i = 0; i < N_LANES; i++) begin : g_lane
    pcs_sync_lane #(
      .ACQ_COMMAS(ACQ_COMMAS), .LOSS_ERRS(LOSS_ERRS),
      .GOOD_RUN(GOOD_RUN), .CNT_W(CNT_W)
    ) u_lane (
      .Clk          (Clk),
      .mr_main_reset(mr_main_reset),
      .power_on     (power_on),
      .cnt_clear    (cnt_clear),
      .i_ind        (PUDI_indicate[i]),
      .i_pudi       (PUDI[10*i +: 10]),
      .o_sudi       (SUDI[11*i +: 11]),
      .o_sudi_valid (SUDI_valid[i]),
      .o_status     (code_sync_status[i]),
      .o_status_nxt (w_stat_nxt[i]),
      .o_loss_cnt   (sync_loss_cnt[CNT_W*i +: CNT_W])
    );
  end

  // Registered from next-state so it moves on the same edge as the lane statuses.
  always_ff @(posedge Clk or posedge mr_main_reset) begin
    if (mr_main_reset) r_all_sync <= 1'b0;
    else               r_all_sync <= &w_stat_nxt;
  end

  assign all_sync = r_all_sync;
endmodule

// File: tb/tb_pcs_sync_multilane.sv
// Scoreboarded bench for pcs_sync_multilane: acquisition, misalignment, hysteresis,
// lane gaps, counter saturation/clear, power_on and async reset.
module tb_pcs_sync_multilane;
  localparam int NL = 4;
  localparam int CW = 2;
  localparam logic [9:0] K  = 10'b0011111010;
  localparam logic [9:0] D  = 10'b1001000101;
  localparam logic [9:0] BD = 10'b0000000000;

  logic                 Clk = 1'b0;
  logic                 mr_main_reset;
  logic                 power_on;
  logic [10*NL-1:0]     PUDI;
  logic [NL-1:0]        PUDI_indicate;
  logic                 cnt_clear;
  logic [11*NL-1:0]     SUDI;
  logic [NL-1:0]        SUDI_valid;
  logic [NL-1:0]        code_sync_status;
  logic                 all_sync;
  logic [CW*NL-1:0]     sync_loss_cnt;

  int n_chk = 0;
  int n_err = 0;
  logic [10:0] sb [NL][$];

  pcs_sync_multilane #(.N_LANES(NL), .ACQ_COMMAS(3), .LOSS_ERRS(4), .GOOD_RUN(4), .CNT_W(CW)) dut (
    .Clk(Clk), .mr_main_reset(mr_main_reset), .power_on(power_on), .PUDI(PUDI),
    .PUDI_indicate(PUDI_indicate), .cnt_clear(cnt_clear), .SUDI(SUDI), .SUDI_valid(SUDI_valid),
    .code_sync_status(code_sync_status), .all_sync(all_sync), .sync_loss_cnt(sync_loss_cnt)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic drive(input int l, input logic [9:0] cg, input logic ev);
    PUDI[10*l +: 10] = cg;
    PUDI_indicate[l] = 1'b1;
    sb[l].push_back({ev, cg});
  endtask

  task automatic tick();
    logic [NL-1:0] exp_v;
    logic [10:0]   e;
    exp_v = PUDI_indicate;
    @(posedge Clk); #1;
    for (int i = 0; i < NL; i++) begin
      chk($sformatf("sudi_valid[%0d]", i), 32'(SUDI_valid[i]), 32'(exp_v[i]));
      if (exp_v[i] && sb[i].size() > 0) begin
        e = sb[i].pop_front();
        chk($sformatf("sudi[%0d]", i), 32'(SUDI[11*i +: 11]), 32'(e));
      end
    end
    PUDI_indicate = '0;
    cnt_clear     = 1'b0;
  endtask

  task automatic send(input int l, input logic [9:0] cg, input logic ev);
    drive(l, cg, ev);
    tick();
  endtask

  task automatic acquire(input int l);
    send(l, K, 1'b1); send(l, D, 1'b0); send(l, K, 1'b1); send(l, D, 1'b0); send(l, K, 1'b1);
  endtask

  task automatic lose(input int l);
    send(l, BD, 1'b0); send(l, BD, 1'b1); send(l, BD, 1'b0); send(l, BD, 1'b1);
  endtask

  function automatic logic [31:0] cnt(input int l);
    return 32'(sync_loss_cnt[CW*l +: CW]);
  endfunction

  initial begin
    mr_main_reset = 1'b1; power_on = 1'b1; PUDI = '0; PUDI_indicate = '0; cnt_clear = 1'b0;
    tick(); tick();
    chk("rst_status", 32'(code_sync_status), 0);
    chk("rst_all_sync", 32'(all_sync), 0);
    chk("rst_sudi", 32'(SUDI), 0);
    chk("rst_cnt", 32'(sync_loss_cnt), 0);
    mr_main_reset = 1'b0;
    tick();

    // lane0 acquires on the third aligned comma
    send(0, K, 1'b1); send(0, D, 1'b0); send(0, K, 1'b1); send(0, D, 1'b0);
    chk("t2_pre_sync", 32'(code_sync_status[0]), 0);
    send(0, K, 1'b1);
    chk("t2_sync", 32'(code_sync_status[0]), 1);
    chk("t2_all_sync", 32'(all_sync), 0);

    // lane1 misaligned comma drops back and must restart the count
    send(1, K, 1'b1); send(1, D, 1'b0); send(1, D, 1'b1); send(1, K, 1'b0);
    chk("t3_status", 32'(code_sync_status[1]), 0);
    chk("t3_cnt", cnt(1), 0);
    send(1, K, 1'b1); send(1, D, 1'b0); send(1, K, 1'b1);
    chk("t3_restart", 32'(code_sync_status[1]), 0);
    send(1, D, 1'b0); send(1, K, 1'b1);
    chk("t3_resync", 32'(code_sync_status[1]), 1);

    // lane2 error hysteresis
    acquire(2);
    chk("t4_sync", 32'(code_sync_status[2]), 1);
    send(2, BD, 1'b0); send(2, BD, 1'b1); send(2, BD, 1'b0);
    chk("t4_err3", 32'(code_sync_status[2]), 1);
    send(2, D, 1'b1); send(2, D, 1'b0); send(2, D, 1'b1); send(2, D, 1'b0);
    send(2, BD, 1'b1);
    chk("t4_still_sync", 32'(code_sync_status[2]), 1);
    chk("t4_cnt0", cnt(2), 0);
    send(2, BD, 1'b0);
    chk("t4_loss", 32'(code_sync_status[2]), 0);
    chk("t4_cnt1", cnt(2), 1);

    // lane3 with indicate gaps while lane2 reacquires
    drive(2, K, 1'b1); drive(3, K, 1'b1); tick();
    send(2, D, 1'b0);
    send(2, K, 1'b1);
    drive(2, D, 1'b0); drive(3, D, 1'b0); tick();
    drive(2, K, 1'b1); drive(3, K, 1'b1); tick();
    chk("t5_l2_sync", 32'(code_sync_status[2]), 1);
    chk("t5_all_sync0", 32'(all_sync), 0);
    tick(); tick();
    chk("t5_l3_hold", 32'(code_sync_status[3]), 0);
    send(3, D, 1'b0);
    send(3, K, 1'b1);
    chk("t5_l3_sync", 32'(code_sync_status[3]), 1);
    chk("t5_all_sync1", 32'(all_sync), 1);
    chk("t5_l0_hold", 32'(code_sync_status[0]), 1);

    // counter saturation at CNT_W=2
    lose(2);
    chk("t6_cnt2", cnt(2), 2);
    chk("t6_all_sync0", 32'(all_sync), 0);
    acquire(2); lose(2);
    chk("t6_cnt3", cnt(2), 3);
    acquire(2); lose(2);
    chk("t6_sat", cnt(2), 3);
    acquire(2);
    send(2, BD, 1'b0); send(2, BD, 1'b1); send(2, BD, 1'b0);
    drive(2, BD, 1'b1); cnt_clear = 1'b1; tick();
    chk("t6_clr_loss", cnt(2), 1);
    chk("t6_clr_status", 32'(code_sync_status[2]), 0);
    acquire(2);
    chk("t6_resync", 32'(code_sync_status[2]), 1);
    power_on = 1'b0;
    send(2, D, 1'b0);
    chk("t6_pwr_status", 32'(code_sync_status), 0);
    chk("t6_pwr_all", 32'(all_sync), 0);
    chk("t6_pwr_cnt", cnt(2), 1);
    power_on = 1'b1;
    cnt_clear = 1'b1; tick();
    chk("t6_clear", 32'(sync_loss_cnt), 0);

    // async reset mid-stream
    acquire(0);
    drive(0, D, 1'b0); tick();
    mr_main_reset = 1'b1; #2;
    chk("t1_status", 32'(code_sync_status), 0);
    chk("t1_valid", 32'(SUDI_valid), 0);
    chk("t1_sudi", 32'(SUDI), 0);
    for (int i = 0; i < NL; i++) sb[i].delete();
    #1 mr_main_reset = 1'b0;
    tick();
    send(0, K, 1'b1);
    chk("t1_post_status", 32'(code_sync_status[0]), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
